// File: rtl/el2_dec_trigger_hit.sv
// el2_dec_trigger_hit
//   Carries the per-trigger instruction-address match vector from decode
//   through X to R. In R it applies trigger chaining, debug-mode suppression
//   and flush kill. It produces the qualified hit, the hit action and the
//   sticky mhit status bits.
//
//   Optional feature macro: RV_TRIGGER_CHAIN_EN
//     defined   - triggers 0/1 and 2/3 may be chained via mtdata1_chain
//     undefined - mtdata1_chain is ignored, every trigger fires on its own
//
// Ports
//   clk                     in   core clock
//   rst                     in   asynchronous active-high reset
//   dec_i0_trigger_match_d  in   [3:0] raw per-trigger match for D instruction
//   dec_i0_decode_d         in   D instruction accepted into X this cycle
//   dec_pipe_stall          in   hold X and R
//   dec_tlu_flush_lower_r   in   kill X and R contents (beats stall/decode)
//   dec_tlu_dbg_halted      in   debug mode, masks all hits combinationally
//   mtdata1_chain           in   [1:0] bit0: trig0<->1, bit1: trig2<->3
//   mtdata1_action          in   [3:0] 1 = enter debug mode, 0 = ebreak
//   mhit_clr                in   [3:0] CSR write clearing sticky hit bits
//   dec_i0_trigger_hit_r    out  [3:0] qualified hit for R instruction
//   trigger_hit_dmode_r     out  hit requests debug-mode entry
//   trigger_hit_ebreak_r    out  hit requests breakpoint exception
//   mhit                    out  [3:0] sticky hit status (registered)
module el2_dec_trigger_hit (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] dec_i0_trigger_match_d,
    input  logic       dec_i0_decode_d,
    input  logic       dec_pipe_stall,
    input  logic       dec_tlu_flush_lower_r,
    input  logic       dec_tlu_dbg_halted,
    input  logic [1:0] mtdata1_chain,
    input  logic [3:0] mtdata1_action,
    input  logic [3:0] mhit_clr,
    output logic [3:0] dec_i0_trigger_hit_r,
    output logic       trigger_hit_dmode_r,
    output logic       trigger_hit_ebreak_r,
    output logic [3:0] mhit
);

    logic [3:0] match_x_q, match_x_d;
    logic [3:0] match_r_q, match_r_d;
    logic       valid_x_q, valid_x_d;
    logic       valid_r_q, valid_r_d;
    logic [3:0] mhit_q, mhit_d;
    logic [3:0] eff;
    logic [3:0] hit;

    // Stage advance. Flush beats stall, and stall beats decode.
    always_comb begin
        match_x_d = match_x_q;
        valid_x_d = valid_x_q;
        match_r_d = match_r_q;
        valid_r_d = valid_r_q;
        if (dec_tlu_flush_lower_r) begin
            match_x_d = 4'b0;
            valid_x_d = 1'b0;
            match_r_d = 4'b0;
            valid_r_d = 1'b0;
        end else if (!dec_pipe_stall) begin
            // A bubble into X also zeroes the match vector.
            match_x_d = dec_i0_decode_d ? dec_i0_trigger_match_d : 4'b0;
            valid_x_d = dec_i0_decode_d;
            match_r_d = match_x_q;
            valid_r_d = valid_x_q;
        end
    end

`ifdef RV_TRIGGER_CHAIN_EN
    // A chained pair fires only when both members matched.
    always_comb begin
        eff[0] = match_r_q[0] & (~mtdata1_chain[0] | match_r_q[1]);
        eff[1] = match_r_q[1] & (~mtdata1_chain[0] | match_r_q[0]);
        eff[2] = match_r_q[2] & (~mtdata1_chain[1] | match_r_q[3]);
        eff[3] = match_r_q[3] & (~mtdata1_chain[1] | match_r_q[2]);
    end
`else
    logic unused_chain;
    assign unused_chain = ^mtdata1_chain;
    assign eff = match_r_q;
`endif

    assign hit                  = eff & {4{valid_r_q & ~dec_tlu_dbg_halted}};
    assign dec_i0_trigger_hit_r = hit;
    assign trigger_hit_dmode_r  = |(hit & mtdata1_action);
    // Debug-mode entry takes priority when both kinds of trigger hit.
    assign trigger_hit_ebreak_r = (|hit) & ~trigger_hit_dmode_r;

    // The set term is applied after the clear term, so a set in the same cycle wins.
    assign mhit_d = (mhit_q & ~mhit_clr) | hit;
    assign mhit   = mhit_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_x_q <= 4'b0;
            valid_x_q <= 1'b0;
            match_r_q <= 4'b0;
            valid_r_q <= 1'b0;
            mhit_q    <= 4'b0;
        end else begin
            match_x_q <= match_x_d;
            valid_x_q <= valid_x_d;
            match_r_q <= match_r_d;
            valid_r_q <= valid_r_d;
            mhit_q    <= mhit_d;
        end
    end

endmodule

// File: tb/tb_el2_dec_trigger_hit.sv
// Self-checking bench for el2_dec_trigger_hit: directed cases followed by
// randomized traffic. Results are compared against a transaction-level model
// that tracks which instruction occupies X and R.
module tb_el2_dec_trigger_hit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] match_d;
    logic       decode_d, stall, flush, halted;
    logic [1:0] chain;
    logic [3:0] action, clr;
    logic [3:0] hit_r, mhit;
    logic       dmode, ebreak;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    el2_dec_trigger_hit dut (
        .clk                    (clk),
        .rst                    (rst),
        .dec_i0_trigger_match_d (match_d),
        .dec_i0_decode_d        (decode_d),
        .dec_pipe_stall         (stall),
        .dec_tlu_flush_lower_r  (flush),
        .dec_tlu_dbg_halted     (halted),
        .mtdata1_chain          (chain),
        .mtdata1_action         (action),
        .mhit_clr               (clr),
        .dec_i0_trigger_hit_r   (hit_r),
        .trigger_hit_dmode_r    (dmode),
        .trigger_hit_ebreak_r   (ebreak),
        .mhit                   (mhit)
    );

    // Model: an instruction slot is either empty or holds a match vector.
    typedef struct {
        bit       occ;
        bit [3:0] m;
    } slot_t;

    slot_t   sx, sr;
    bit [3:0] mh;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    function automatic bit [3:0] fire(input bit [3:0] m, input bit [1:0] ch);
        bit [3:0] e;
        e = m;
`ifdef RV_TRIGGER_CHAIN_EN
        for (int p = 0; p < 2; p++)
            if (ch[p] && !(m[2*p] && m[2*p+1])) begin
                e[2*p]   = 1'b0;
                e[2*p+1] = 1'b0;
            end
`endif
        return e;
    endfunction

    task automatic model_reset();
        sx = '{occ: 1'b0, m: 4'b0};
        sr = '{occ: 1'b0, m: 4'b0};
        mh = 4'b0;
    endtask

    task automatic set_idle();
        match_d = 4'b0; decode_d = 1'b0; stall = 1'b0; flush = 1'b0;
        halted = 1'b0; chain = 2'b0; action = 4'b0; clr = 4'b0;
    endtask

    // Called just after a negedge with inputs already applied. The task
    // checks outputs, then advances one clock edge and returns at the next negedge.
    task automatic cyc(input string tag);
        bit [3:0] eh;
        slot_t    nx, nr;
        #1;
        eh = (sr.occ && !halted) ? fire(sr.m, chain) : 4'b0;
        chk({tag, ".hit"},    hit_r,            eh);
        chk({tag, ".dmode"},  {3'b0, dmode},    {3'b0, (eh & action) != 0});
        chk({tag, ".ebreak"}, {3'b0, ebreak},   {3'b0, eh != 0 && (eh & action) == 0});
        chk({tag, ".mhit"},   mhit,             mh);
        nx = sx; nr = sr;
        if (flush) begin
            nx.occ = 0; nx.m = 0; nr.occ = 0; nr.m = 0;
        end else if (!stall) begin
            nr = sx;
            nx.occ = decode_d;
            nx.m   = decode_d ? match_d : 4'b0;
        end
        for (int i = 0; i < 4; i++)
            if (eh[i]) mh[i] = 1'b1;
            else if (clr[i]) mh[i] = 1'b0;
        @(posedge clk);
        sx = nx; sr = nr;
        @(negedge clk);
    endtask

    // Push one instruction through D and one bubble so it reaches R.
    task automatic issue(input bit [3:0] m, input string tag);
        match_d = m; decode_d = 1'b1; cyc({tag, ".d"});
        match_d = 4'b0; decode_d = 1'b0; cyc({tag, ".x"});
    endtask

    initial begin
        set_idle();
        model_reset();
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst.hit", hit_r, 4'b0);
        chk("rst.mhit", mhit, 4'b0);
        @(negedge clk);
        rst = 1'b0;

        // Basic: a single trigger with the ebreak action.
        issue(4'b0001, "basic");
        cyc("basic.r");
        cyc("basic.mhit");

        // Chaining behaviour; the model covers both builds.
        chain = 2'b01;
        issue(4'b0001, "ch1"); cyc("ch1.r");
        issue(4'b0011, "ch2"); cyc("ch2.r");
        chain = 2'b00;

        // Mixed action values: debug mode has priority.
        action = 4'b1000;
        issue(4'b1010, "act"); cyc("act.r");
        action = 4'b0000;

        // Flush while the instruction is in X.
        match_d = 4'b0100; decode_d = 1'b1; cyc("fl.d");
        match_d = 4'b0; decode_d = 1'b0; flush = 1'b1; cyc("fl.x");
        flush = 1'b0; cyc("fl.r");

        // Stall for three cycles while the hit is in R.
        issue(4'b0010, "st");
        stall = 1'b1; cyc("st.r0"); cyc("st.r1"); cyc("st.r2");
        stall = 1'b0; cyc("st.r3");

        // Debug halted: outputs are masked and mhit is unchanged.
        issue(4'b1000, "dbg");
        halted = 1'b1; cyc("dbg.r");
        halted = 1'b0; cyc("dbg.after");

        // Sticky mhit: a set in the same cycle as a clear wins; a clear alone clears.
        clr = 4'b1111; cyc("clrall");
        clr = 4'b0;
        issue(4'b0100, "mh"); cyc("mh.r"); // mhit becomes 0100
        issue(4'b0100, "mh2");
        clr = 4'b0100; cyc("mh2.r");       // set and clear in the same cycle
        cyc("mh2.keep");                   // mhit remains 0100
        cyc("mh2.clr");                    // clear alone
        clr = 4'b0; cyc("mh2.zero");

        // Flush with a hit in R: the hit is still reported in that cycle.
        issue(4'b0001, "flr");
        flush = 1'b1; cyc("flr.r");
        flush = 1'b0; cyc("flr.after");

        // Randomized traffic, including mid-run asynchronous resets.
        for (int n = 0; n < 400; n++) begin
            match_d  = 4'($urandom);
            decode_d = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 9) == 0);
            halted   = ($urandom_range(0, 6) == 0);
            chain    = 2'($urandom);
            action   = 4'($urandom) & 4'($urandom);
            clr      = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0;
            if (n % 97 == 50) begin
                rst = 1'b1;
                #1;
                model_reset();
                chk("arst.hit", hit_r, 4'b0);
                chk("arst.mhit", mhit, 4'b0);
                @(negedge clk);
                rst = 1'b0;
            end else begin
                cyc("rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
